aes_stream_loader: RTL and testbench
====================================

# aes_stream_loader

Upstream/downstream adapter for `aes_encrypt` or `aes_decrypt`. It accepts a 32-bit word stream through a valid/ready handshake and packs four words into a 128-bit block. It then issues the block to the AES core with a one-cycle `load`, waits for the core's `valid`, captures the 128-bit result, and streams it back out as four 32-bit words. The block replaces the static test vectors and switch-driven `load` of the board-level harness with a real data path.

## Interface
Parameters:
- `MAX_WAIT`, default 64: cycles allowed in WAIT before timeout; must be ≥ 1.
- `CW`, default `$clog2(MAX_WAIT+1)`: wait-counter width; derived, not overridden.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 32: input word; first word of a block is bits [127:96].
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader accepts a word when `in_valid && in_ready`.
- `out_data` out 32: result word; first word is bits [127:96].
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: sink accepts when `out_valid && out_ready`.
- `aes_in` out 128: block to the AES core (`pt` of encrypt / `ct` of decrypt).
- `aes_load` out 1: one-cycle start pulse to the core.
- `aes_out` in 128: core result.
- `aes_valid` in 1: core result valid; pulse or level.
- `busy` out 1: high in LOAD, WAIT or DRAIN.
- `err` out 1: one-cycle pulse on timeout.

## Operation
- States: FILL, LOAD, WAIT, DRAIN. Reset enters FILL with word count 0.
- FILL:
  - `in_ready=1`.
  - Each accepted word shifts in: `blk <= {blk[95:0], in_data}`.
  - The count increments on each accept. The 4th accept (count 3) sets count to 0 and moves to LOAD.
- LOAD:
  - `aes_load=1` for exactly one cycle, then go to WAIT.
  - The wait counter clears to 0.
  - `aes_valid` is ignored in this state.
- WAIT:
  - `aes_in` holds `blk` unchanged, and `in_ready=0`.
  - `aes_valid_q` registers `aes_valid` every cycle.
  - On a rising edge (`aes_valid && !aes_valid_q`): `res <= aes_out`, then go to DRAIN.
    - A `valid` left high from a previous operation is not treated as a new result.
  - Otherwise the wait counter increments.
  - When the counter reaches `MAX_WAIT` without a rising edge: pulse `err` for one cycle, discard the block, return to FILL.
- DRAIN:
  - `out_valid=1`, `out_data = res[127-32*cnt -: 32]`.
  - Each `out_valid && out_ready` increments the count. The 4th accept clears the count and returns to FILL.
  - `out_data` is stable while `out_ready=0`.
- `aes_in` is driven from `blk` at all times. It changes only during FILL accepts.
- Key handling is outside this block; the key must be static from LOAD until DRAIN.
- Reset asserted mid-operation: immediately returns to FILL with count 0. `blk`, `res` and `aes_valid_q` clear to 0. No partial block is ever emitted.

## Timing
- Reset values:
  - `in_ready=1` (state FILL); no accept occurs before the first rising edge after `rst_n` deasserts.
  - `out_valid=0`, `aes_load=0`, `busy=0`, `err=0`.
  - `out_data=0`, `aes_in=0`.
- `in_ready`, `out_valid`, `aes_load`, `busy` and `out_data` decode from registered state only. There is no combinational path from `in_valid` or `out_ready`.
- Minimum block cycle: 4 (FILL) + 1 (LOAD) + N (WAIT, where N is the cycle count from LOAD until the core raises `valid`) + 4 (DRAIN) cycles.
- `aes_load` goes high in the cycle after the 4th input accept.
- `out_valid` goes high in the cycle after the `aes_valid` rising edge is sampled.
- `err` goes high in the cycle after the counter reaches `MAX_WAIT`, concurrent with `in_ready` returning to 1.
- There is no input/output overlap: input is stalled until the last result word is accepted.

## Structure
- Package `aes_loader_pkg`:
  - `typedef enum logic [1:0] {FILL, LOAD, WAIT, DRAIN} loader_state_t`
  - `localparam WORDS_PER_BLOCK = 4`
  - `localparam WORD_W = 32`
- Single module, no sub-module. The 128-bit input shift register, result register, 2-bit word counter and wait counter are inline.
- Imports the existing `flops.svh` async-reset flop macros for all state.

## Test plan
- **FIPS-197 AES-128 vector:** `aes_stream_loader` connected to `aes_encrypt` (Nk=4), key `000102030405060708090a0b0c0d0e0f`; send words `00112233, 44556677, 8899aabb, ccddeeff` -> one `aes_load` pulse; output words `69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a` in that order.
- **Decrypt round trip:** connected to `aes_decrypt`, feed the four result words above -> outputs `00112233 … ccddeeff`.
- **Backpressure:** `in_valid` toggled 1-0-1; `out_ready` held 0 for 5 cycles during DRAIN -> no lost or duplicated words, `out_data` stable while stalled, output matches the reference vector.
- **Timeout:** `MAX_WAIT=8`, model core never raises `aes_valid` -> `err` high exactly 1 cycle, 8 cycles after `aes_load`; `in_ready=1` and no `out_valid`; a following good block completes correctly.
- **Stuck-high valid:** model core holds `aes_valid=1` continuously from the previous block -> no capture without a fresh low-to-high edge; timeout fires.
- **Reset mid-WAIT and mid-DRAIN:** assert `rst_n=0` for 1 cycle -> all outputs return to reset values within the reset cycle; the next full block processes correctly.

Source files
------------

// File: rtl/aes_loader_pkg.sv
// Shared types and sizes for the AES stream loader: FSM states and word/block geometry.
package aes_loader_pkg;

  typedef enum logic [1:0] {FILL, LOAD, WAIT, DRAIN} loader_state_t;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLK_W           = WORDS_PER_BLOCK * WORD_W;

endpackage

// File: rtl/aes_stream_loader.sv
// Packs four 32-bit words into a 128-bit block for an AES core, starts it with a one-cycle
// load, waits (bounded) for a fresh valid edge, then streams the result out as four words.
module aes_stream_loader
  import aes_loader_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLK_W-1:0]    aes_in,
  output logic                aes_load,
  input  logic [BLK_W-1:0]    aes_out,
  input  logic                aes_valid,
  output logic                busy,
  output logic                err
);

  loader_state_t     state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [BLK_W-1:0]  res_q, res_d;
  logic              aes_valid_q;
  logic              err_q, err_d;
  logic              in_fire;
  logic              out_fire;
  logic              valid_rise;

  // Handshake outputs decode from registered state only.
  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == DRAIN);
  assign aes_load   = (state_q == LOAD);
  assign busy       = (state_q != FILL);
  assign err        = err_q;
  assign aes_in     = blk_q;

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  // A valid level left over from an earlier block must not count as a new result.
  assign valid_rise = aes_valid && !aes_valid_q;

  always_comb begin
    out_data = res_q[BLK_W-1 -: WORD_W];
    case (cnt_q)
      2'd0:    out_data = res_q[BLK_W-1            -: WORD_W];
      2'd1:    out_data = res_q[BLK_W-1 -   WORD_W -: WORD_W];
      2'd2:    out_data = res_q[BLK_W-1 - 2*WORD_W -: WORD_W];
      default: out_data = res_q[BLK_W-1 - 3*WORD_W -: WORD_W];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    blk_d   = blk_q;
    res_d   = res_q;
    err_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (in_fire) begin
          blk_d = {blk_q[BLK_W-WORD_W-1:0], in_data};
          if (cnt_q == 2'(WORDS_PER_BLOCK - 1)) begin
            cnt_d   = 2'd0;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      LOAD: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (valid_rise) begin
          res_d   = aes_out;
          state_d = DRAIN;
        end else if (wcnt_q + CW'(1) == CW'(MAX_WAIT)) begin
          // Core never answered: drop the block and go back to accepting input.
          wcnt_d  = '0;
          err_d   = 1'b1;
          state_d = FILL;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (cnt_q == 2'(WORDS_PER_BLOCK - 1)) begin
            cnt_d   = 2'd0;
            state_d = FILL;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= 2'd0;
      wcnt_q      <= '0;
      blk_q       <= '0;
      res_q       <= '0;
      aes_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      blk_q       <= blk_d;
      res_q       <= res_d;
      aes_valid_q <= aes_valid;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed bench for aes_stream_loader with a behavioural AES core model (FIPS-197 pair or XOR pattern).
module tb_aes_stream_loader;

  localparam int MW = 8;
  localparam logic [127:0] PT   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] MASK = {4{32'ha5a5a5a5}};

  logic         clk;
  logic         rst_n;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] aes_in;
  logic         aes_load;
  logic [127:0] aes_out;
  logic         aes_valid;
  logic         busy;
  logic         err;

  aes_stream_loader #(.MAX_WAIT(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aes_in    (aes_in),
    .aes_load  (aes_load),
    .aes_out   (aes_out),
    .aes_valid (aes_valid),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Core model: mode 0 answers after core_lat cycles, 1 never answers, 2 holds valid high.
  int   core_mode;
  int   core_lat;
  logic pend;
  int   lat_cnt;

  function automatic logic [127:0] core_f(input logic [127:0] x);
    if (x == PT) return CT;
    if (x == CT) return PT;
    return x ^ MASK;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      lat_cnt   <= 0;
      aes_valid <= 1'b0;
      aes_out   <= '0;
    end else if (core_mode == 2) begin
      aes_valid <= 1'b1;
    end else begin
      aes_valid <= 1'b0;
      if (aes_load && core_mode == 0) begin
        pend    <= 1'b1;
        lat_cnt <= core_lat;
      end else if (pend) begin
        if (lat_cnt <= 1) begin
          aes_valid <= 1'b1;
          aes_out   <= core_f(aes_in);
          pend      <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    int           lat;
    bit           gap;
    bit           stall;
  } vec_t;

  vec_t vecs[5];

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic put_word(input logic [31:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk_b("in_ready_bound", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic put_block(input logic [127:0] b, input bit gap);
    for (int k = 0; k < 4; k++) begin
      put_word(b[127-32*k -: 32]);
      if (gap && k < 3) @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk_b({tag, "_in_ready"},  in_ready,  1'b1);
    chk_b({tag, "_out_valid"}, out_valid, 1'b0);
    chk_b({tag, "_aes_load"},  aes_load,  1'b0);
    chk_b({tag, "_busy"},      busy,      1'b0);
    chk_b({tag, "_err"},       err,       1'b0);
    chk_w({tag, "_out_data"},  128'(out_data), 128'd0);
    chk_w({tag, "_aes_in"},    aes_in,    128'd0);
  endtask

  task automatic run_block(input vec_t v, input string tag);
    int n = 0;
    logic [31:0] d;
    core_mode = 0;
    core_lat  = v.lat;
    put_block(v.din, v.gap);
    chk_b({tag, "_load"},      aes_load, 1'b1);
    chk_b({tag, "_in_stall"},  in_ready, 1'b0);
    chk_b({tag, "_busy"},      busy,     1'b1);
    chk_w({tag, "_aes_in"},    aes_in,   v.din);
    @(negedge clk);
    chk_b({tag, "_load_once"}, aes_load, 1'b0);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_b({tag, "_out_valid"}, out_valid, 1'b1);
    chk_w({tag, "_latency"}, 128'(n), 128'(v.lat + 1));
    for (int k = 0; k < 4; k++) begin
      if (v.stall && k == 1) begin
        out_ready = 1'b0;
        d = out_data;
        repeat (5) begin
          @(negedge clk);
          chk_w({tag, "_stall_data"}, 128'(out_data), 128'(d));
        end
        chk_b({tag, "_stall_valid"}, out_valid, 1'b1);
      end
      out_ready = 1'b1;
      chk_w({tag, "_word"}, 128'(out_data), 128'(v.dout[127-32*k -: 32]));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk_b({tag, "_done_in_ready"},  in_ready,  1'b1);
    chk_b({tag, "_done_out_valid"}, out_valid, 1'b0);
    chk_b({tag, "_done_busy"},      busy,      1'b0);
  endtask

  task automatic timeout_block(input logic [127:0] b, input int mode, input string tag);
    int err_cnt = 0;
    int first   = -1;
    bit saw_ov  = 1'b0;
    core_mode = mode;
    put_block(b, 1'b0);
    chk_b({tag, "_load"}, aes_load, 1'b1);
    for (int k = 1; k <= MW + 4; k++) begin
      @(negedge clk);
      if (err) begin
        err_cnt++;
        if (first < 0) first = k;
      end
      if (out_valid) saw_ov = 1'b1;
      if (k == MW + 1) chk_b({tag, "_in_ready_at_err"}, in_ready, 1'b1);
    end
    chk_w({tag, "_err_cycles"}, 128'(err_cnt), 128'd1);
    chk_w({tag, "_err_time"},   128'(first),   128'(MW + 1));
    chk_b({tag, "_no_out"},     saw_ov,        1'b0);
    core_mode = 0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{din: PT, dout: CT, lat: 1, gap: 1'b0, stall: 1'b0};
    vecs[1] = '{din: CT, dout: PT, lat: 3, gap: 1'b1, stall: 1'b1};
    vecs[2] = '{din: 128'd0, dout: MASK, lat: 2, gap: 1'b0, stall: 1'b0};
    vecs[3] = '{din: 128'h12345678_9abcdef0_0f0f0f0f_deadbeef,
                dout: 128'hb791f3dd_3f197b55_aaaaaaaa_7b081b4a, lat: 5, gap: 1'b0, stall: 1'b0};
    vecs[4] = '{din: {4{32'hffffffff}}, dout: {4{32'h5a5a5a5a}}, lat: 1, gap: 1'b1, stall: 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    core_mode = 0;
    core_lat  = 1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    timeout_block(128'h01020304_05060708_090a0b0c_0d0e0f10, 1, "timeout");
    run_block(vecs[0], "after_timeout");

    core_mode = 2;
    aes_out   = '0;
    repeat (3) @(negedge clk);
    timeout_block(PT, 2, "stuck");
    run_block(vecs[2], "after_stuck");

    // Reset while the core is still working.
    core_mode = 0;
    core_lat  = 6;
    put_block(vecs[3].din, 1'b0);
    repeat (3) @(negedge clk);
    chk_b("midwait_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midwait_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(vecs[3], "after_midwait");

    // Reset after two of four result words have left.
    core_lat = 1;
    put_block(vecs[2].din, 1'b0);
    repeat (3) @(negedge clk);
    chk_b("middrain_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    chk_w("middrain_word3", 128'(out_data), 128'(32'ha5a5a5a5));
    rst_n = 1'b0;
    #1;
    check_reset_vals("middrain_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(vecs[0], "after_middrain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
